// File: rtl/starflux_pkg.sv
// ============================================================================
// Module      : starflux_pkg
// Description : Screen geometry, coordinate types and bitmap index helper
//               shared by the bullet producer and the VGA scan datapath.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package starflux_pkg;

  localparam int SCREEN_W  = 160;
  localparam int SCREEN_H  = 120;
  localparam int GRID_BITS = SCREEN_W * SCREEN_H;

  typedef logic [7:0] xcoord_t;
  typedef logic [6:0] ycoord_t;

  function automatic logic [14:0] grid_idx(input xcoord_t x, input ycoord_t y);
    return 15'(int'(y) * SCREEN_W + int'(x));
  endfunction

endpackage

`default_nettype wire

// File: rtl/bullet_slot.sv
// ============================================================================
// Module      : bullet_slot
// Description : One bullet table entry: move on tick, retire at the top edge
//               or on enemy contact, load on spawn.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bullet_slot
  import starflux_pkg::*;
(
  input  logic    clk,
  input  logic    resetn_i,
  input  logic    clear_i,
  input  logic    tick_i,
  input  logic    load_i,
  input  xcoord_t load_x_i,
  input  ycoord_t load_y_i,
  input  xcoord_t enemy_x_i,
  input  ycoord_t enemy_y_i,
  output logic    valid_o,
  output xcoord_t bx_o,
  output ycoord_t by_o,
  output logic    free_o,
  output logic    hit_o
);

  logic    valid_q;
  xcoord_t bx_q;
  ycoord_t by_q;

  logic    w_mv_valid;
  ycoord_t w_mv_y;
  logic    w_collide;

  // Collision is judged on the post-move position, so it only applies on ticks.
  always_comb begin
    w_mv_valid = valid_q;
    w_mv_y     = by_q;
    if (tick_i && valid_q) begin
      if (by_q == 7'd0) begin
        w_mv_valid = 1'b0;
      end else begin
        w_mv_y = by_q - 7'd1;
      end
    end
    w_collide = tick_i && w_mv_valid && (bx_q == enemy_x_i) && (w_mv_y == enemy_y_i);
  end

  assign free_o  = !(w_mv_valid && !w_collide);
  assign hit_o   = w_collide;
  assign valid_o = valid_q;
  assign bx_o    = bx_q;
  assign by_o    = by_q;

  always_ff @(posedge clk) begin
    if (!resetn_i || clear_i) begin
      valid_q <= 1'b0;
      bx_q    <= '0;
      by_q    <= '0;
    end else if (load_i) begin
      valid_q <= 1'b1;
      bx_q    <= load_x_i;
      by_q    <= load_y_i;
    end else begin
      valid_q <= w_mv_valid && !w_collide;
      by_q    <= w_mv_y;
    end
  end

endmodule

`default_nettype wire

// File: rtl/bullet_grid_writer.sv
// ============================================================================
// Module      : bullet_grid_writer
// Description : Player bullet table with spawn/move/collide and a registered
//               flat bitmap for the scan datapath.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bullet_grid_writer
  import starflux_pkg::*;
#(
  parameter int NUM_BULLETS = 8,
  parameter int SCREEN_W    = 160,
  parameter int SCREEN_H    = 120
) (
  input  logic                               clk,
  input  logic                               resetn,
  input  logic                               clear_en,
  input  logic                               fire,
  input  logic                               tick,
  input  logic [7:0]                         user_x,
  input  logic [6:0]                         user_y,
  input  logic [7:0]                         enemy_x,
  input  logic [6:0]                         enemy_y,
  output logic [SCREEN_W*SCREEN_H-1:0]       grid,
  output logic                               fire_ack,
  output logic                               hit,
  output logic [$clog2(NUM_BULLETS+1)-1:0]   bullet_count,
  output logic                               full
);

  localparam int c_CNT_W = $clog2(NUM_BULLETS + 1);

  logic [NUM_BULLETS-1:0] w_valid;
  logic [NUM_BULLETS-1:0] w_free;
  logic [NUM_BULLETS-1:0] w_hit;
  logic [NUM_BULLETS-1:0] w_pick;
  logic [NUM_BULLETS-1:0] w_load;
  xcoord_t                w_bx [NUM_BULLETS];
  ycoord_t                w_by [NUM_BULLETS];
  logic                   w_any_free;
  logic                   w_spawn;

  logic [SCREEN_W*SCREEN_H-1:0] grid_d, grid_q;
  logic [c_CNT_W-1:0]           count_d, count_q;
  logic                         full_q;
  logic                         fire_ack_q;
  logic                         hit_q;

  generate
    for (genvar i = 0; i < NUM_BULLETS; i++) begin : g_slots
      bullet_slot u_slot (
        .clk       (clk),
        .resetn_i  (resetn),
        .clear_i   (clear_en),
        .tick_i    (tick),
        .load_i    (w_load[i]),
        .load_x_i  (user_x),
        .load_y_i  (user_y - 7'd1),
        .enemy_x_i (enemy_x),
        .enemy_y_i (enemy_y),
        .valid_o   (w_valid[i]),
        .bx_o      (w_bx[i]),
        .by_o      (w_by[i]),
        .free_o    (w_free[i]),
        .hit_o     (w_hit[i])
      );
    end
  endgenerate

  // Free flags already account for this cycle's retires, so a slot vacated
  // by a move or collision can be reused by a same-cycle spawn.
  always_comb begin
    w_pick     = '0;
    w_any_free = 1'b0;
    for (int i = 0; i < NUM_BULLETS; i++) begin
      if (w_free[i] && !w_any_free) begin
        w_pick[i]  = 1'b1;
        w_any_free = 1'b1;
      end
    end
  end

  assign w_spawn = fire && w_any_free && (user_y != 7'd0) && (user_x < 8'(SCREEN_W));
  assign w_load  = w_pick & {NUM_BULLETS{w_spawn}};

  always_comb begin
    grid_d  = '0;
    count_d = '0;
    for (int i = 0; i < NUM_BULLETS; i++) begin
      if (w_valid[i]) begin
        grid_d[grid_idx(w_bx[i], w_by[i])] = 1'b1;
      end
      count_d = count_d + c_CNT_W'(w_valid[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn || clear_en) begin
      grid_q     <= '0;
      count_q    <= '0;
      full_q     <= 1'b0;
      fire_ack_q <= 1'b0;
      hit_q      <= 1'b0;
    end else begin
      grid_q     <= grid_d;
      count_q    <= count_d;
      full_q     <= &w_valid;
      fire_ack_q <= w_spawn;
      hit_q      <= |w_hit;
    end
  end

  assign grid         = grid_q;
  assign bullet_count = count_q;
  assign full         = full_q;
  assign fire_ack     = fire_ack_q;
  assign hit          = hit_q;

endmodule

`default_nettype wire

// File: doc/bullet_grid_writer.md
# bullet_grid_writer

Producer side of the bullet bitmap consumed by the VGA scan datapath. The block keeps a small table of active player bullets. It spawns a bullet at the ship position on a fire request and advances every bullet upward by one row per movement tick. It retires bullets that leave the screen or strike the enemy ship. Each cycle it rebuilds the flat 160x120 `grid` vector that the scan datapath samples while painting the screen.

## Interface
Parameters:
- `NUM_BULLETS`, default 8: slot-table depth, maximum simultaneous bullets.
- `SCREEN_W`, default 160: columns, x range 0..159.
- `SCREEN_H`, default 120: rows, y range 0..119.

Ports (one clock; reset is synchronous and active-low):
- `clk` in 1: system clock (50 MHz board clock).
- `resetn` in 1: synchronous active-low reset.
- `clear_en` in 1: synchronous game-restart clear. Same effect as reset, active-high.
- `fire` in 1: single-cycle spawn request.
- `tick` in 1: single-cycle movement strobe (one per frame).
- `user_x` in 8: ship x.
- `user_y` in 7: ship y.
- `enemy_x` in 8: enemy x.
- `enemy_y` in 7: enemy y.
- `grid` out 19200: bullet bitmap. Bit index is y*160 + x. 1 means a bullet is present.
- `fire_ack` out 1: one-cycle pulse, spawn accepted.
- `hit` out 1: one-cycle pulse, a bullet struck the enemy.
- `bullet_count` out $clog2(NUM_BULLETS+1): number of valid slots.
- `full` out 1: all slots valid.

## Operation
- Slot state per entry: `valid`, `bx[7:0]`, `by[6:0]`. Reset or `clear_en` sets all `valid` to 0 and zeroes `bx` and `by`.
- Reset values of outputs: `grid` = 0, `fire_ack` = 0, `hit` = 0, `bullet_count` = 0, `full` = 0.
- Per-cycle update order: movement first, then collision and retire, then spawn.
- Movement: on `tick`, every valid slot with `by` == 0 is invalidated (leaves the screen). Every other valid slot has `by` decremented by 1. There is no x motion.
- Collision: evaluated after the move, on `tick` cycles only. Any valid slot with (`bx`,`by`) == (`enemy_x`,`enemy_y`) is invalidated. `hit` pulses once even if several slots match.
- Spawn: a spawn is accepted when all of the following hold:
  - `fire` = 1;
  - at least one slot is free after this cycle's retires;
  - `user_y` != 0;
  - `user_x` < 160.
- On an accepted spawn, the lowest-index free slot is loaded with (`user_x`, `user_y`-1) and `fire_ack` pulses.
- A spawned bullet is not moved in its spawn cycle, even if `tick` is also high.
- A rejected fire is dropped silently. There is no queueing.
- A spawn coincident with the enemy position is not a hit until the next `tick`.
- Width rule: coordinates never exceed 159/119. Decrementing from 0 is prevented by the retire rule, so no wrap-around occurs.
- `grid` is rebuilt from the slot table as an OR of one-hot decodes of each valid slot. Duplicate positions set one bit.
- `clear_en` has priority over `fire` and `tick` in the same cycle.
- Reset or `clear_en` asserted mid-operation discards all slots immediately.

## Timing
- Slot table updates on the clock edge that samples `fire`/`tick`.
- `grid`, `bullet_count` and `full` are registered from the slot table. Each reflects a slot change 1 cycle after the table updates, i.e. 2 edges after the stimulus.
- `fire_ack` and `hit` are registered and are high for the cycle immediately after the sampling edge.
- `tick` and `fire` are level-sampled each cycle. Holding `fire` high spawns one bullet per cycle until `full`.
- No backpressure from the consumer. The consumer may sample `grid` at any cycle; values change only on clock edges.

## Structure
- Shared package `starflux_pkg`:
  - constants `SCREEN_W`, `SCREEN_H`, `GRID_BITS` (19200);
  - coordinate typedefs `xcoord_t` [7:0] and `ycoord_t` [6:0];
  - index function `grid_idx(x,y)` = y*SCREEN_W + x, also used by the scan datapath.
- One sub-module is natural: `bullet_slot`. It holds one entry's valid/x/y, performs move/retire/collide and the load on spawn, and outputs its own hit flag. The top level instantiates `NUM_BULLETS` of them, plus a priority encoder for free-slot selection and the grid OR-decode.

## Test plan
- Reset hold: `resetn`=0 for 3 cycles with `fire`=1 -> `grid`=0, `bullet_count`=0, no `fire_ack`.
- Spawn: `user`=(80,100), single `fire` -> `fire_ack` next cycle; `grid` bit 99*160+80 = 1 two edges later; `bullet_count`=1.
- Move and exit: bullet at (10,1), three `tick`s -> y=0 after the first, slot retired on the second, `grid`=0 and `bullet_count`=0 thereafter.
- Collision: bullet at (40,51), enemy (40,50), one `tick` -> `hit` pulses once, slot freed, bit 50*160+40 stays 0.
- Full: hold `fire` for 10 cycles at `user`=(5,60) -> exactly 8 `fire_ack`s, `full`=1, 9th and 10th fires dropped; `user_y`=0 fire with a free slot -> no `fire_ack`.
- Simultaneous: `fire`+`tick` same cycle with one existing bullet at (20,30), `user`=(70,90) -> old bullet at (20,29), new bullet at (70,89); `clear_en` in the same cycle instead -> table empty.
